// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and flag positions for the ALU command sequencer
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10,
    ST_RESP = 2'b11
  } seq_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Compare runs on the subtractor; load-imm rides the adder with B forced to zero.
  function automatic logic [2:0] alu_ctrl_for(input logic [2:0] op);
    case (op)
      OP_CMP:  return OP_SUB;
      OP_LDI:  return OP_ADD;
      default: return op;
    endcase
  endfunction

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NUM_REGS x 8 operand register file, two async reads, one sync write
module alu_regfile #(
  parameter int  NUM_REGS = 4,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] ra_addr,
  output logic [7:0]      ra_data,
  input  logic [RA_W-1:0] rb_addr,
  output logic [7:0]      rb_data,
  input  logic            we,
  input  logic [RA_W-1:0] wa_addr,
  input  logic [7:0]      w_data
);

  logic [7:0] regs [NUM_REGS];

  // Clear wins over write so a reset during writeback leaves every register at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wa_addr] <= w_data;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - serialises commands through the external ALU and returns result plus flags
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int  NUM_REGS = 4,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [RA_W-1:0] cmd_rd,
  input  logic [RA_W-1:0] cmd_rs,
  input  logic            cmd_use_imm,
  input  logic [7:0]      cmd_imm,
  input  logic [1:0]      cmd_shamt,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_ctrl,
  output logic [1:0]      alu_shamt,
  input  logic [7:0]      alu_result,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic            alu_carry,
  input  logic            alu_ovf,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [7:0]      rsp_data,
  output logic [3:0]      rsp_flags
);

  seq_state_t      state, state_nxt;
  logic            accept;
  logic            rf_we;
  logic [7:0]      rd_val, rs_val;
  logic [7:0]      rf_wdata;
  logic [3:0]      alu_flags, flags_nxt;

  logic [2:0]      op_q;
  logic [RA_W-1:0] rd_q;
  logic [7:0]      imm_q;
  logic [7:0]      a_q, b_q;
  logic [2:0]      ctrl_q;
  logic [1:0]      shamt_q;
  logic [7:0]      res_q;
  logic [3:0]      sflags_q;
  logic [3:0]      flags_q;
  logic [7:0]      rsp_data_q;
  logic [3:0]      rsp_flags_q;

  alu_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (cmd_rd),
    .ra_data (rd_val),
    .rb_addr (cmd_rs),
    .rb_data (rs_val),
    .we      (rf_we),
    .wa_addr (rd_q),
    .w_data  (rf_wdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; ready is masked during the reset cycle itself.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && cmd_ready) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_WB;
      ST_WB: begin
        rf_we     = (op_q != OP_CMP);
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;

  // Pack the ALU flags into the {N,Z,C,V} layout and pick writeback values.
  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_neg;
    alu_flags[FLAG_Z] = alu_zero;
    alu_flags[FLAG_C] = alu_carry;
    alu_flags[FLAG_V] = alu_ovf;
    rf_wdata          = (op_q == OP_LDI) ? imm_q : res_q;
    flags_nxt         = (op_q == OP_LDI) ? flags_q : sflags_q;
  end

  // Datapath: latch command and operands on accept, sample ALU in EXEC, commit in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      shamt_q     <= '0;
      res_q       <= '0;
      sflags_q    <= '0;
      flags_q     <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= cmd_op;
        rd_q    <= cmd_rd;
        imm_q   <= cmd_imm;
        a_q     <= rd_val;
        b_q     <= (cmd_op == OP_LDI) ? 8'h00 : (cmd_use_imm ? cmd_imm : rs_val);
        ctrl_q  <= alu_ctrl_for(cmd_op);
        shamt_q <= is_shift(cmd_op) ? cmd_shamt : 2'b00;
      end
      if (state == ST_EXEC) begin
        res_q    <= alu_result;
        sflags_q <= alu_flags;
      end
      if (state == ST_WB) begin
        flags_q     <= flags_nxt;
        rsp_data_q  <= rf_wdata;
        rsp_flags_q <= flags_nxt;
      end
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = ctrl_q;
  assign alu_shamt = shamt_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer with a behavioural ALU
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_rs;
  logic       cmd_use_imm;
  logic [7:0] cmd_imm;
  logic [1:0] cmd_shamt;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_ctrl;
  logic [1:0] alu_shamt;
  logic [7:0] alu_result;
  logic       alu_zero, alu_neg, alu_carry, alu_ovf;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [7:0] data;
    logic [3:0] flags;
    string      tag;
  } exp_t;

  exp_t sb[$];

  alu_cmd_sequencer #(.NUM_REGS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rs      (cmd_rs),
    .cmd_use_imm (cmd_use_imm),
    .cmd_imm     (cmd_imm),
    .cmd_shamt   (cmd_shamt),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_shamt   (alu_shamt),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_neg     (alu_neg),
    .alu_carry   (alu_carry),
    .alu_ovf     (alu_ovf),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_flags   (rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for ALU_simple: carry is carry-out on add, borrow on sub, last bit out on shifts.
  logic [8:0] alu_tmp;
  always_comb begin
    alu_tmp    = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        alu_tmp    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_tmp[7:0];
        alu_carry  = alu_tmp[8];
        alu_ovf    = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      3'b001: begin
        alu_tmp    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = alu_tmp[7:0];
        alu_carry  = alu_tmp[8];
        alu_ovf    = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: begin
        alu_tmp    = {1'b0, alu_a} << alu_shamt;
        alu_result = alu_tmp[7:0];
        alu_carry  = alu_tmp[8];
      end
      3'b101: begin
        alu_tmp    = {alu_a, 1'b0} >> alu_shamt;
        alu_result = alu_tmp[8:1];
        alu_carry  = alu_tmp[0];
      end
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);
  assign alu_neg  = alu_result[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completed response handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_rsp: got data %0h flags %0h with nothing expected", rsp_data, rsp_flags);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_data"}, {24'h0, rsp_data}, {24'h0, e.data});
        check({e.tag, "_flags"}, {28'h0, rsp_flags}, {28'h0, e.flags});
      end
    end
  end

  task automatic drive_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                           input logic use_imm, input logic [7:0] imm, input logic [1:0] shamt);
    cmd_op      = op;
    cmd_rd      = rd;
    cmd_rs      = rs;
    cmd_use_imm = use_imm;
    cmd_imm     = imm;
    cmd_shamt   = shamt;
    cmd_valid   = 1'b1;
  endtask

  // Waits for cmd_ready, issues one command and checks the N+3 response latency.
  task automatic send_cmd(input string tag, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs, input logic use_imm, input logic [7:0] imm,
                          input logic [1:0] shamt, input logic [7:0] exp_data,
                          input logic [3:0] exp_flags);
    exp_t e;
    int   waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!cmd_ready && waited < 20);
    if (!cmd_ready) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    drive_cmd(op, rd, rs, use_imm, imm, shamt);
    e.data  = exp_data;
    e.flags = exp_flags;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check({tag, "_exec_ready"}, {31'h0, cmd_ready}, 32'd0);
    check({tag, "_exec_valid"}, {31'h0, rsp_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_wb_valid"}, {31'h0, rsp_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_resp_valid"}, {31'h0, rsp_valid}, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) check({tag, "_drain_timeout"}, sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_op       = '0;
    cmd_rd       = '0;
    cmd_rs       = '0;
    cmd_use_imm  = 1'b0;
    cmd_imm      = '0;
    cmd_shamt    = '0;
    rsp_ready    = 1'b1;

    @(negedge clk);
    @(negedge clk);
    check("reset_cmd_ready", {31'h0, cmd_ready}, 32'd0);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {31'h0, cmd_ready}, 32'd1);
    check("post_reset_outs", {rsp_data, rsp_flags, alu_a, alu_b[3:0]}, 32'h0);
    check("post_reset_alu", {27'h0, alu_ctrl, alu_shamt}, 32'h0);

    send_cmd("ldi_r0",  3'b110, 2'd0, 2'd0, 1'b1, 8'h7F, 2'd0, 8'h7F, 4'b0000);
    wait_drain("ldi_r0");
    send_cmd("ldi_r1",  3'b110, 2'd1, 2'd0, 1'b1, 8'h01, 2'd0, 8'h01, 4'b0000);
    wait_drain("ldi_r1");
    send_cmd("add_r0",  3'b000, 2'd0, 2'd1, 1'b0, 8'h00, 2'd0, 8'h80, 4'b1001);
    wait_drain("add_r0");
    send_cmd("rd_r0",   3'b011, 2'd0, 2'd0, 1'b1, 8'h00, 2'd0, 8'h80, 4'b1000);
    wait_drain("rd_r0");
    send_cmd("ldi_r2",  3'b110, 2'd2, 2'd0, 1'b1, 8'h00, 2'd0, 8'h00, 4'b1000);
    wait_drain("ldi_r2");
    send_cmd("sub_r2",  3'b001, 2'd2, 2'd0, 1'b1, 8'h01, 2'd0, 8'hFF, 4'b1010);
    wait_drain("sub_r2");
    send_cmd("cmp_r2",  3'b111, 2'd2, 2'd0, 1'b1, 8'hFF, 2'd0, 8'h00, 4'b0100);
    wait_drain("cmp_r2");
    send_cmd("rd_r2",   3'b011, 2'd2, 2'd0, 1'b1, 8'h00, 2'd0, 8'hFF, 4'b1000);
    wait_drain("rd_r2");
    send_cmd("ldi_r3",  3'b110, 2'd3, 2'd0, 1'b1, 8'hC1, 2'd0, 8'hC1, 4'b1000);
    wait_drain("ldi_r3");
    send_cmd("shl_r3",  3'b100, 2'd3, 2'd0, 1'b0, 8'h00, 2'd1, 8'h82, 4'b1010);
    wait_drain("shl_r3");

    // Backpressure: response held for 5 cycles with a stray command pulse in the window.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send_cmd("shr_r3",  3'b101, 2'd3, 2'd0, 1'b0, 8'h00, 2'd2, 8'h20, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'h0, rsp_valid}, 32'd1);
      check("bp_data", {24'h0, rsp_data}, 32'h20);
      check("bp_flags", {28'h0, rsp_flags}, 32'h2);
      check("bp_cmd_ready", {31'h0, cmd_ready}, 32'd0);
      if (i == 1) drive_cmd(3'b110, 2'd0, 2'd0, 1'b1, 8'hAA, 2'd0);
      if (i == 2) cmd_valid = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain("shr_r3");
    @(negedge clk);
    check("bp_after_valid", {31'h0, rsp_valid}, 32'd0);
    send_cmd("rd_r0_bp", 3'b011, 2'd0, 2'd0, 1'b1, 8'h00, 2'd0, 8'h80, 4'b1000);
    wait_drain("rd_r0_bp");
    send_cmd("add_r1r1", 3'b000, 2'd1, 2'd1, 1'b0, 8'h00, 2'd0, 8'h02, 4'b0000);
    wait_drain("add_r1r1");

    // Reset during WB of ADD r1, imm 0x10: no response, registers and flags cleared.
    begin
      int waited;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!cmd_ready && waited < 20);
      check("rst_wb_ready_in", {31'h0, cmd_ready}, 32'd1);
      drive_cmd(3'b000, 2'd1, 2'd0, 1'b1, 8'h10, 2'd0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("rst_wb_cmd_ready", {31'h0, cmd_ready}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_wb_ready_after", {31'h0, cmd_ready}, 32'd1);
      check("rst_wb_rsp_zero", {23'h0, rsp_valid, rsp_data}, 32'h0);
      check("rst_wb_flags_zero", {28'h0, rsp_flags}, 32'h0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("rst_wb_no_rsp", {31'h0, rsp_valid}, 32'd0);
      end
    end
    send_cmd("ldi_r3_post", 3'b110, 2'd3, 2'd0, 1'b1, 8'h55, 2'd0, 8'h55, 4'b0000);
    wait_drain("ldi_r3_post");
    send_cmd("rd_r1_post",  3'b011, 2'd1, 2'd0, 1'b1, 8'h00, 2'd0, 8'h00, 4'b0100);
    wait_drain("rd_r1_post");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
